regfile_wb_arbiter: RTL and testbench
=====================================

Name: regfile_wb_arbiter

Overview:
- Shares the register file's single write port among NREQ writeback requesters (e.g. ALU, load unit, multiplier).
- Round-robin grant, valid/ready handshake per requester, one registered output stage.
- Output stage drives the register file's write-enable/address/data pins directly and is also exported as a bypass source.
- Sits between the execute/memory writeback paths and the register file.

Parameters:
- NREQ, 3, number of requesters; legal range 2..8.
- ADDR_W, 5, register address width.
- DATA_W, 32, write data width.

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  NREQ  bit i: requester i has a write pending.
- req_addr  in  NREQ*ADDR_W  slice i = [i*ADDR_W +: ADDR_W], requester i destination register.
- req_data  in  NREQ*DATA_W  slice i = [i*DATA_W +: DATA_W], requester i write data.
- req_ready  out  NREQ  bit i: requester i accepted this cycle (one-hot or zero).
- wb_stall  in  1  downstream freeze; while high no write retires.
- RegWrite  out  1  register file write enable.
- wAddr  out  ADDR_W  register file write address.
- wDin  out  DATA_W  register file write data.
- fwd_valid  out  1  output stage holds an unretired write.
- fwd_addr  out  ADDR_W  output stage address (bypass compare).
- fwd_data  out  DATA_W  output stage data (bypass value).

Behaviour:
- State:
  - out_valid, out_addr, out_data: the output stage.
  - rr_ptr: $clog2(NREQ) bits, the highest-priority requester.
- Reset (async, rst_n low): out_valid=0, out_addr=0, out_data=0, rr_ptr=0. All outputs are therefore 0 and req_ready=0 while rst_n is low. Reset mid-operation discards the held write; it is never performed.
- Combinational outputs:
  - RegWrite = out_valid & ~wb_stall.
  - wAddr = fwd_addr = out_addr; wDin = fwd_data = out_data.
  - fwd_valid = out_valid.
- Accept condition: can_accept = ~out_valid | ~wb_stall. The stage is empty, or it retires this cycle.
- Grant:
  - If can_accept and any req_valid, grant the first set bit scanning rr_ptr, rr_ptr+1, ..., wrapping modulo NREQ.
  - req_ready[g] = 1 for the granted index g only. It is combinational from req_valid, rr_ptr and wb_stall.
  - A requester transfers when req_valid & req_ready are both high. It must hold addr/data stable until then.
- Load: on a grant, out_valid<=1, out_addr<=req_addr[g], out_data<=req_data[g], rr_ptr<=(g+1) mod NREQ.
- Retire without a new grant: out_valid<=0, out_addr/out_data hold their values.
- Stall: while wb_stall=1 and out_valid=1, the stage and rr_ptr hold and req_ready=0.
- rr_ptr changes only on a grant, never on idle or stall cycles.
- Latency: accepted at cycle t, RegWrite high at cycle t+1 if wb_stall is low at t+1. Sustained throughput is one write per cycle.
- Simultaneous retire and accept in the same cycle is legal and back-to-back.
- No address-collision merging: two writes to the same register are performed in grant order.
- Address 0 is written like any other address unless the optional feature is enabled.

Optional Feature:
- Macro: REGFILE_WB_ZERO_DROP_EN.
- Defined:
  - A granted request with addr==0 is acknowledged (req_ready=1, rr_ptr advances) but does not load the output stage; out_valid is unchanged by it.
  - If the stage retires in that same cycle, out_valid<=0.
  - Such requests never assert RegWrite or fwd_valid.
- Undefined: address 0 is treated like any other address.

Decomposition:
- Package regfile_wb_pkg:
  - ADDR_W=5 and DATA_W=32 constants.
  - a NREQ_DEFAULT=3 constant.
  - helper function next_idx(idx, n) = (idx+1) mod n.
- Sub-module rr_arbiter (parameter N):
  - Inputs: req[N-1:0], ptr, en.
  - Outputs: one-hot gnt[N-1:0], gnt_idx, any.
  - Purely combinational; the pointer register stays in the parent.

Test Plan:
- Reset: drive req_valid=3'b111 with rst_n=0 -> req_ready=0, RegWrite=0, wAddr=0, wDin=0. Release reset -> first grant goes to requester 0 (rr_ptr=0).
- Round-robin: hold req_valid=3'b111 with addr 1/2/3, data 0xA/0xB/0xC -> grants 0,1,2,0 on consecutive cycles. RegWrite high from the second cycle, wAddr sequence 1,2,3,1.
- Pointer wrap and skip: rr_ptr=2, req_valid=3'b011 -> grant 0, rr_ptr becomes 1. Next cycle req_valid=3'b100 -> grant 2, rr_ptr wraps to 0.
- Stall:
  - Load addr 5, data 0x55, then assert wb_stall for 3 cycles with req_valid=3'b010 -> RegWrite=0, req_ready=0, fwd_valid=1, fwd_addr=5 throughout.
  - Drop wb_stall -> RegWrite=1 with wAddr=5 and wDin=0x55. Requester 1 is granted in that same cycle.
- Reset mid-operation: assert rst_n=0 while out_valid=1 -> fwd_valid and RegWrite drop immediately (asynchronously); the held write is never performed after release.
- REGFILE_WB_ZERO_DROP_EN:
  - Requester 0 writes addr 0, then addr 4 -> req_ready[0] pulses for both. RegWrite asserts only for wAddr=4.
  - With the macro undefined, RegWrite asserts for wAddr=0 then wAddr=4.

Source files
------------

// File: rtl/regfile_wb_pkg.sv
// regfile_wb_pkg: shared widths and index helper for the writeback arbiter
package regfile_wb_pkg;
    localparam int ADDR_W       = 5;
    localparam int DATA_W       = 32;
    localparam int NREQ_DEFAULT = 3;
    function automatic int next_idx(input int idx, input int n);
        return (idx + 1) % n;
    endfunction
endpackage

// File: rtl/regfile_wb_arbiter_rr_arbiter.sv
// rr_arbiter: combinational round-robin pick, scanning upward from ptr with wrap
module rr_arbiter #(
    parameter int N  = 3,
    parameter int PW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    input  logic          en,
    output logic [N-1:0]  gnt,
    output logic [PW-1:0] gnt_idx,
    output logic          any
);
    import regfile_wb_pkg::*;
    int w_dist;
    int w_best;
    // pick the requester with the smallest wrapped distance from ptr
    always_comb begin
        gnt_idx = '0;
        any     = 1'b0;
        w_best  = N;
        w_dist  = 0;
        for (int i = 0; i < N; i++) begin
            w_dist = (i + N - int'(ptr)) % N;
            if (en && req[i] && w_dist < w_best) begin
                w_best  = w_dist;
                gnt_idx = PW'(i);
                any     = 1'b1;
            end
        end
    end
    // expand the winning index to one-hot
    always_comb begin
        gnt = '0;
        for (int i = 0; i < N; i++)
            gnt[i] = any && (gnt_idx == PW'(i));
    end
endmodule

// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter: round-robin share of the register-file write port with one registered output stage
// Optional: define REGFILE_WB_ZERO_DROP_EN to acknowledge but discard writes to address 0.
module regfile_wb_arbiter #(
    parameter int NREQ   = regfile_wb_pkg::NREQ_DEFAULT,
    parameter int ADDR_W = regfile_wb_pkg::ADDR_W,
    parameter int DATA_W = regfile_wb_pkg::DATA_W
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NREQ-1:0]          req_valid,
    input  logic [NREQ*ADDR_W-1:0]   req_addr,
    input  logic [NREQ*DATA_W-1:0]   req_data,
    output logic [NREQ-1:0]          req_ready,
    input  logic                     wb_stall,
    output logic                     RegWrite,
    output logic [ADDR_W-1:0]        wAddr,
    output logic [DATA_W-1:0]        wDin,
    output logic                     fwd_valid,
    output logic [ADDR_W-1:0]        fwd_addr,
    output logic [DATA_W-1:0]        fwd_data
);
    import regfile_wb_pkg::*;
    localparam int PW = $clog2(NREQ);
    logic              r_valid;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_data;
    logic [PW-1:0]     r_ptr;
    logic              w_can_accept;
    logic              w_any;
    logic              w_load;
    logic [NREQ-1:0]   w_gnt;
    logic [PW-1:0]     w_gnt_idx;
    logic [ADDR_W-1:0] w_sel_addr;
    logic [DATA_W-1:0] w_sel_data;

    assign w_can_accept = ~r_valid | ~wb_stall;

    rr_arbiter #(.N(NREQ), .PW(PW)) u_arb (
        .req     (req_valid),
        .ptr     (r_ptr),
        .en      (w_can_accept),
        .gnt     (w_gnt),
        .gnt_idx (w_gnt_idx),
        .any     (w_any)
    );

    // no requester may see an acknowledge while the block is held in reset
    assign req_ready = w_gnt & {NREQ{rst_n}};
    assign RegWrite  = r_valid & ~wb_stall;
    assign wAddr     = r_addr;
    assign wDin      = r_data;
    assign fwd_valid = r_valid;
    assign fwd_addr  = r_addr;
    assign fwd_data  = r_data;

    // route the granted requester's address and data to the stage input
    always_comb begin
        w_sel_addr = '0;
        w_sel_data = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (w_gnt_idx == PW'(i)) begin
                w_sel_addr = req_addr[i*ADDR_W +: ADDR_W];
                w_sel_data = req_data[i*DATA_W +: DATA_W];
            end
        end
    end

`ifdef REGFILE_WB_ZERO_DROP_EN
    assign w_load = w_any & (|w_sel_addr);
`else
    assign w_load = w_any;
`endif

    // output stage and priority pointer; a grant both advances the pointer and (normally) reloads the stage
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid <= 1'b0;
            r_addr  <= '0;
            r_data  <= '0;
            r_ptr   <= '0;
        end else begin
            if (w_any)
                r_ptr <= PW'(next_idx(int'(w_gnt_idx), NREQ));
            if (w_load) begin
                r_valid <= 1'b1;
                r_addr  <= w_sel_addr;
                r_data  <= w_sel_data;
            end else if (RegWrite) begin
                r_valid <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// tb_regfile_wb_arbiter: directed vectors checked against a behavioural model plus literal expectations
module tb_regfile_wb_arbiter;
    localparam int N  = 3;
    localparam int AW = 5;
    localparam int DW = 32;
`ifdef REGFILE_WB_ZERO_DROP_EN
    localparam bit ZD = 1'b1;
`else
    localparam bit ZD = 1'b0;
`endif

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic [N-1:0]    req_valid = '0;
    logic [N*AW-1:0] req_addr = '0;
    logic [N*DW-1:0] req_data = '0;
    logic [N-1:0]    req_ready;
    logic            wb_stall = 1'b0;
    logic            RegWrite;
    logic [AW-1:0]   wAddr;
    logic [DW-1:0]   wDin;
    logic            fwd_valid;
    logic [AW-1:0]   fwd_addr;
    logic [DW-1:0]   fwd_data;

    int total = 0;
    int bad = 0;

    bit m_valid;
    int m_addr, m_data, m_ptr, m_g;

    logic [N-1:0]  s_ready;
    logic          s_we, s_fv;
    logic [AW-1:0] s_addr, s_fa;
    logic [DW-1:0] s_data;

    regfile_wb_arbiter dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_addr  (req_addr),
        .req_data  (req_data),
        .req_ready (req_ready),
        .wb_stall  (wb_stall),
        .RegWrite  (RegWrite),
        .wAddr     (wAddr),
        .wDin      (wDin),
        .fwd_valid (fwd_valid),
        .fwd_addr  (fwd_addr),
        .fwd_data  (fwd_data)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic int exp_grant();
        if (!rst_n || (m_valid && wb_stall)) return -1;
        for (int k = 0; k < N; k++) begin
            int i;
            i = (m_ptr + k) % N;
            if (req_valid[i]) return i;
        end
        return -1;
    endfunction

    task automatic mreset();
        m_valid = 1'b0;
        m_addr  = 0;
        m_data  = 0;
        m_ptr   = 0;
    endtask

    task automatic cmp();
        m_g = exp_grant();
        chk("req_ready", 32'(req_ready), m_g < 0 ? 32'd0 : 32'(1 << m_g));
        chk("RegWrite", 32'(RegWrite), 32'(m_valid && !wb_stall));
        chk("wAddr", 32'(wAddr), 32'(m_addr));
        chk("wDin", wDin, 32'(m_data));
        chk("fwd_valid", 32'(fwd_valid), 32'(m_valid));
        chk("fwd_addr", 32'(fwd_addr), 32'(m_addr));
        chk("fwd_data", fwd_data, 32'(m_data));
        s_ready = req_ready;
        s_we    = RegWrite;
        s_addr  = wAddr;
        s_data  = wDin;
        s_fv    = fwd_valid;
        s_fa    = fwd_addr;
    endtask

    task automatic upd();
        int a;
        if (m_valid && !wb_stall) m_valid = 1'b0;
        if (m_g >= 0) begin
            a = int'(req_addr[m_g*AW +: AW]);
            m_ptr = (m_g + 1) % N;
            if (!ZD || a != 0) begin
                m_valid = 1'b1;
                m_addr  = a;
                m_data  = int'(req_data[m_g*DW +: DW]);
            end
        end
    endtask

    task automatic cyc();
        @(negedge clk);
        cmp();
        @(posedge clk);
        if (rst_n) upd();
        #1;
    endtask

    task automatic set_req(input int i, input int a, input int d);
        req_addr[i*AW +: AW] = AW'(a);
        req_data[i*DW +: DW] = DW'(d);
    endtask

    initial begin
        int rr_rdy[5] = '{1, 2, 4, 1, 2};
        int rr_wa[5]  = '{0, 1, 2, 3, 1};
        mreset();
        set_req(0, 1, 'hA);
        set_req(1, 2, 'hB);
        set_req(2, 3, 'hC);
        req_valid = 3'b111;
        #3;
        chk("rst_ready", 32'(req_ready), 0);
        chk("rst_we", 32'(RegWrite), 0);
        chk("rst_waddr", 32'(wAddr), 0);
        chk("rst_wdin", wDin, 0);
        cyc();
        rst_n = 1'b1;
        for (int k = 0; k < 5; k++) begin
            cyc();
            chk("rr_ready", 32'(s_ready), rr_rdy[k]);
            chk("rr_we", 32'(s_we), 32'(k > 0));
            if (k > 0) chk("rr_waddr", 32'(s_addr), rr_wa[k]);
        end
        req_valid = 3'b000;
        cyc();
        req_valid = 3'b011;
        cyc();
        chk("wrap_ready", 32'(s_ready), 1);
        req_valid = 3'b100;
        cyc();
        chk("skip_ready", 32'(s_ready), 4);
        set_req(0, 5, 'h55);
        set_req(1, 7, 'h77);
        req_valid = 3'b001;
        cyc();
        chk("ptr0_ready", 32'(s_ready), 1);
        req_valid = 3'b010;
        wb_stall = 1'b1;
        repeat (3) begin
            cyc();
            chk("stall_we", 32'(s_we), 0);
            chk("stall_ready", 32'(s_ready), 0);
            chk("stall_fv", 32'(s_fv), 1);
            chk("stall_fa", 32'(s_fa), 5);
        end
        wb_stall = 1'b0;
        cyc();
        chk("unstall_we", 32'(s_we), 1);
        chk("unstall_waddr", 32'(s_addr), 5);
        chk("unstall_wdin", s_data, 'h55);
        chk("unstall_ready", 32'(s_ready), 2);
        req_valid = 3'b000;
        cyc();
        req_valid = 3'b001;
        cyc();
        req_valid = 3'b000;
        wb_stall = 1'b1;
        #1;
        chk("pre_rst_fv", 32'(fwd_valid), 1);
        rst_n = 1'b0;
        #1;
        mreset();
        chk("arst_fv", 32'(fwd_valid), 0);
        chk("arst_we", 32'(RegWrite), 0);
        chk("arst_fa", 32'(fwd_addr), 0);
        cyc();
        rst_n = 1'b1;
        wb_stall = 1'b0;
        cyc();
        chk("post_rst_we", 32'(s_we), 0);
        set_req(0, 0, 'hDEAD);
        req_valid = 3'b001;
        cyc();
        chk("z0_ready", 32'(s_ready), 1);
        set_req(0, 4, 'h44);
        cyc();
        chk("z4_ready", 32'(s_ready), 1);
        chk("z_we0", 32'(s_we), ZD ? 32'd0 : 32'd1);
        chk("z_waddr0", 32'(s_addr), 0);
        req_valid = 3'b000;
        cyc();
        chk("z_we4", 32'(s_we), 1);
        chk("z_waddr4", 32'(s_addr), 4);
        chk("z_wdin4", s_data, 'h44);
        cyc();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
